// File: rtl/bin2bcd_seq_pkg.sv
//------------------------------------------------------------------------------
// Module : bin2bcd_seq_pkg
// Brief  : Shared state encoding and digit-count helper for bin2bcd_seq.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package bin2bcd_seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Decimal digits required to represent 2**bin_w-1 (bin_w limited to 63).
  function automatic int bcd_digits_needed(input int bin_w);
    longint unsigned maxv;
    longint unsigned pow;
    int              n;
    maxv = (64'd1 << bin_w) - 64'd1;
    pow  = 64'd10;
    n    = 1;
    while ((maxv >= pow) && (n < 19)) begin
      n   = n + 1;
      pow = pow * 64'd10;
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq_bcd_adj3.sv
//------------------------------------------------------------------------------
// Module : bcd_adj3
// Brief  : Double-dabble digit correction: add 3 to any digit of 5 or more.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_adj3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
//------------------------------------------------------------------------------
// Module : bin2bcd_seq
// Brief  : Sequential shift-and-add-3 binary to packed BCD, one bit per clock.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     lz_blank
);

  localparam int                 CNT_W    = $clog2(BIN_W + 1);
  localparam int                 BCD_W    = 4 * DIGITS;
  localparam logic [CNT_W-1:0]   c_last   = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0]  c_lz_rst = ~(DIGITS'(1));

  if (bcd_digits_needed(BIN_W) > DIGITS) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd;
  logic [DIGITS-1:0]  r_lz;

  logic               w_load;
  logic               w_last;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_scratch_nxt;
  logic [BIN_W-1:0]   w_shift_nxt;
  logic [DIGITS-1:0]  w_lz;
  logic               w_zero;
  logic               w_unused_adj_msb;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_adj3 u_adj (
      .i_digit (r_scratch[4*gi +: 4]),
      .o_digit (w_adj[4*gi +: 4])
    );
  end

  // The top digit never exceeds 9 after adjust+shift, so its MSB is always dropped.
  assign w_unused_adj_msb = w_adj[BCD_W-1];
  assign w_scratch_nxt    = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
  assign w_shift_nxt      = {r_shift[BIN_W-2:0], 1'b0};

  assign w_load = (r_state == ST_IDLE)  && start;
  assign w_last = (r_state == ST_SHIFT) && (r_cnt == c_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start)  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last) w_state_nxt = ST_IDLE;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  // Leading-zero mask from the value about to be published.
  always_comb begin
    w_lz   = '0;
    w_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero  = w_zero & (w_scratch_nxt[4*i +: 4] == 4'd0);
      w_lz[i] = w_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_lz      <= c_lz_rst;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_shift   <= bin;
        r_scratch <= '0;
        r_cnt     <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_shift   <= w_shift_nxt;
        r_scratch <= w_scratch_nxt;
        r_cnt     <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_bcd  <= w_scratch_nxt;
          r_lz   <= w_lz;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign lz_blank = r_lz;

endmodule

`default_nettype wire
